// File: rtl/rv_pkg.sv
// Shared RV32 constants and types for the fetch stage and the decode control unit.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-to-decode instruction handshake between IF (master) and ID (slave).
interface if_fetch_stage_if;
    import rv_pkg::*;

    // A transfer completes on every rising edge where out_valid && out_ready.
    // While out_valid is high and out_ready is low, the payload is held stable.
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus4;

    modport master (
        output out_valid, out_instr, out_pc, out_pc_plus4,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_instr, out_pc, out_pc_plus4,
        output out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry {instr, pc} buffer with synchronous flush; flush overrides push and pop.
module fetch_fifo
    import rv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t rdata_o,
    output logic [AW:0]  count_o
);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        do_push  = push_i & ~flush_i;
        do_pop   = pop_i & ~flush_i & (count_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    push_when_full_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(do_push && !do_pop && count_q == (AW+1)'(DEPTH)));

endmodule

// File: rtl/if_fetch_stage.sv
// RV32 instruction-fetch stage: PC, 1-cycle imem requests, credit-limited buffer, EX redirects.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module if_fetch_stage
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic [XLEN-1:0]     imem_rdata,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    if_fetch_stage_if.master    id_if
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_bubbles
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic [AW:0]     count;
    logic [AW+1:0]   occ_after_pop;
    logic            out_valid, pop;
    fetch_entry_t    head, push_entry;
    logic            unused_redirect_lsb;

    assign out_valid     = (count != '0);
    assign pop           = out_valid & id_if.out_ready;
    // Credit check: a new request is allowed only if its response is sure to find a free slot.
    assign occ_after_pop = (AW+2)'(count) + (AW+2)'(inflight_q) - (AW+2)'(pop);
    assign imem_req      = rst_n & ~redirect_valid & (occ_after_pop < (AW+2)'(DEPTH));
    assign imem_addr     = fetch_pc_q;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = imem_req;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (imem_req) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    // A response landing in a redirect cycle is discarded by the flush.
    assign push_entry = '{instr: imem_rdata, pc: inflight_pc_q};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head),
        .count_o (count)
    );

    assign id_if.out_valid    = out_valid;
    assign id_if.out_instr    = out_valid ? head.instr : NOP_INSTR;
    assign id_if.out_pc       = out_valid ? head.pc : '0;
    assign id_if.out_pc_plus4 = id_if.out_pc + 32'd4;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_bubbles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            if (pop)        perf_fetched_q <= perf_fetched_q + 32'd1;
            if (!out_valid) perf_bubbles_q <= perf_bubbles_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule
